truxton2_eeprom: RTL and testbench

Serial 93C46-compatible NVRAM responder (64 x 16-bit words) that completes the CPU's bit-banged EEPROM lines (EEPROM_SCS / EEPROM_SCLK / EEPROM_SDI / EEPROM_SDO) in the truxton2 game top level. The CPU is the initiator and this block is the responder. It decodes start bit, opcode and address, and executes READ, WRITE, ERASE, EWEN, EWDS, ERAL and WRAL. A parallel host port lets the loader save and restore contents.

---
 rtl/truxton2_eeprom.sv | 247 ++++++++++++++++++++++++
 tb/tb_truxton2_eeprom.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truxton2_eeprom.sv
// truxton2_eeprom
// 93C46-style serial NVRAM responder, 64 x 16-bit words, for the truxton2
// CPU bit-banged EEPROM lines, plus a parallel host port for save/restore.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset (memory contents kept)
//   EEPROM_SCS   chip select from CPU, active high
//   EEPROM_SCLK  serial clock from CPU (oversampled on CLK)
//   EEPROM_SDI   serial data from CPU
//   EEPROM_SDO   serial data / ready status to CPU
//   HOST_ADDR    host word address
//   HOST_DIN     host write data
//   HOST_WE      host write strobe
//   HOST_DOUT    registered read of HOST_ADDR
//   DIRTY        set when the CPU commits a write or erase
//
// state | meaning
// IDLE  | skipping leading zeros, waiting for the start bit
// OPC   | shifting the 2 opcode bits
// ADDR  | shifting the 6 address bits, decode on the last one
// RD    | streaming words out on SDO
// DIN   | shifting the 16 data bits of WRITE / WRAL
// ARM   | command complete, waiting for SCS to fall
// BUSY  | self-timed program/erase period
module truxton2_eeprom #(
  parameter int WRITE_BUSY_CYCLES = 4800
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EEPROM_SCS,
  input  logic        EEPROM_SCLK,
  input  logic        EEPROM_SDI,
  output logic        EEPROM_SDO,
  input  logic [5:0]  HOST_ADDR,
  input  logic [15:0] HOST_DIN,
  input  logic        HOST_WE,
  output logic [15:0] HOST_DOUT,
  output logic        DIRTY
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPC  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_DIN  = 3'd4;
  localparam logic [2:0] ST_ARM  = 3'd5;
  localparam logic [2:0] ST_BUSY = 3'd6;

  localparam int              BW        = $clog2(WRITE_BUSY_CYCLES + 1);
  localparam logic [BW-1:0]   BUSY_LOAD = BW'(WRITE_BUSY_CYCLES - 1);

  logic [15:0]   mem [64];

  logic [2:0]    state;
  logic          scs_s, sclk_s, sdi_s, sclk_d;
  logic          sclk_rise;
  logic [1:0]    op;
  logic [5:0]    addr;
  logic [5:0]    addr_nx;
  logic [15:0]   din;
  logic [3:0]    bit_cnt;
  logic          wen;
  logic          sdo_bit;
  logic [BW-1:0] busy_cnt;
  logic [5:0]    wr_ptr;
  logic [6:0]    wr_left;
  logic [15:0]   wr_data;
  logic          int_we;
  logic          commit_ok;

  // Sample stage for the CPU lines; these are plain pipeline flops and carry
  // no architectural state, so they are left out of reset.
  always_ff @(posedge CLK) begin
    scs_s  <= EEPROM_SCS;
    sclk_s <= EEPROM_SCLK;
    sdi_s  <= EEPROM_SDI;
    sclk_d <= sclk_s;
  end

  assign sclk_rise = sclk_s & ~sclk_d & scs_s;
  assign addr_nx   = {addr[4:0], sdi_s};

  // Bulk ops write one word per CLK while BUSY; WRITE_BUSY_CYCLES must be at
  // least 64 for ERAL/WRAL to reach every word.
  assign int_we = (state == ST_BUSY) && (wr_left != 7'd0);

  always_comb begin
    commit_ok = 1'b0;
    if (wen) begin
      case (op)
        2'b01, 2'b11: commit_ok = 1'b1;
        2'b00:        commit_ok = (addr[5:4] == 2'b10) || (addr[5:4] == 2'b01);
        default:      commit_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      op       <= 2'b00;
      addr     <= 6'd0;
      din      <= 16'd0;
      bit_cnt  <= 4'd0;
      wen      <= 1'b0;
      sdo_bit  <= 1'b1;
      busy_cnt <= '0;
      wr_ptr   <= 6'd0;
      wr_left  <= 7'd0;
      wr_data  <= 16'd0;
      DIRTY    <= 1'b0;
    end else begin
      if (int_we) begin
        wr_ptr  <= wr_ptr + 6'd1;
        wr_left <= wr_left - 7'd1;
      end
      case (state)
        ST_IDLE: begin
          if (sclk_rise && sdi_s) begin
            state   <= ST_OPC;
            bit_cnt <= 4'd0;
          end
        end
        ST_OPC: begin
          if (!scs_s) begin
            state <= ST_IDLE;
          end else if (sclk_rise) begin
            op <= {op[0], sdi_s};
            if (bit_cnt == 4'd1) begin
              state   <= ST_ADDR;
              bit_cnt <= 4'd0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_ADDR: begin
          if (!scs_s) begin
            state <= ST_IDLE;
          end else if (sclk_rise) begin
            addr <= addr_nx;
            if (bit_cnt == 4'd5) begin
              bit_cnt <= 4'd0;
              case (op)
                2'b10: begin
                  state   <= ST_RD;
                  sdo_bit <= 1'b0;
                  bit_cnt <= 4'd15;
                end
                2'b01:   state <= ST_DIN;
                2'b11:   state <= ST_ARM;
                default: begin
                  if (addr_nx[5:4] == 2'b11) wen <= 1'b1;
                  if (addr_nx[5:4] == 2'b00) wen <= 1'b0;
                  state <= (addr_nx[5:4] == 2'b01) ? ST_DIN : ST_ARM;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_RD: begin
          if (!scs_s) begin
            state <= ST_IDLE;
          end else if (sclk_rise) begin
            sdo_bit <= mem[addr][bit_cnt];
            if (bit_cnt == 4'd0) begin
              addr    <= addr + 6'd1;
              bit_cnt <= 4'd15;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        ST_DIN: begin
          if (!scs_s) begin
            state <= ST_IDLE;
          end else if (sclk_rise) begin
            din <= {din[14:0], sdi_s};
            if (bit_cnt == 4'd15) begin
              state <= ST_ARM;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_ARM: begin
          if (!scs_s) begin
            if (commit_ok) begin
              state    <= ST_BUSY;
              busy_cnt <= BUSY_LOAD;
              DIRTY    <= 1'b1;
              case (op)
                2'b01: begin
                  wr_ptr  <= addr;
                  wr_left <= 7'd1;
                  wr_data <= din;
                end
                2'b11: begin
                  wr_ptr  <= addr;
                  wr_left <= 7'd1;
                  wr_data <= 16'hFFFF;
                end
                default: begin
                  wr_ptr  <= 6'd0;
                  wr_left <= 7'd64;
                  wr_data <= (addr[5:4] == 2'b01) ? din : 16'hFFFF;
                end
              endcase
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_BUSY: begin
          if (busy_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single write port: a commit write in the same cycle drops the host write.
  // Deliberately outside reset so a loader can restore contents at any time.
  always_ff @(posedge CLK) begin
    if (int_we) begin
      mem[wr_ptr] <= wr_data;
    end else if (HOST_WE) begin
      mem[HOST_ADDR] <= HOST_DIN;
    end
    HOST_DOUT <= mem[HOST_ADDR];
  end

  always_comb begin
    if (!scs_s)                EEPROM_SDO = 1'b1;
    else if (state == ST_RD)   EEPROM_SDO = sdo_bit;
    else if (state == ST_BUSY) EEPROM_SDO = 1'b0;
    else                       EEPROM_SDO = 1'b1;
  end

endmodule

// File: tb/tb_truxton2_eeprom.sv
// tb_truxton2_eeprom
// Drives the CPU serial protocol and host port of truxton2_eeprom and checks
// results against an array-level model of the 93C46 command set.
module tb_truxton2_eeprom;

  localparam int BUSY_N = 100;
  // Commit: SCS low is sampled one CLK, acted on the next, then BUSY_N CLKs.
  localparam int COMMIT_CYC = BUSY_N + 2;
  // No commit: ready is seen on the first sample after SCS returns high.
  localparam int IDLE_CYC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        scs, sclk, sdi;
  logic        sdo;
  logic [5:0]  host_addr;
  logic [15:0] host_din;
  logic        host_we;
  logic [15:0] host_dout;
  logic        dirty;

  int tests = 0;
  int fails = 0;

  logic [15:0] model_mem [64];
  bit          model_wen;
  bit          model_dirty;

  logic [15:0] rd_q [$];
  logic        rd_dummy;
  int          busy_cyc;
  logic        first_sdo;

  truxton2_eeprom #(.WRITE_BUSY_CYCLES(BUSY_N)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .EEPROM_SCS  (scs),
    .EEPROM_SCLK (sclk),
    .EEPROM_SDI  (sdi),
    .EEPROM_SDO  (sdo),
    .HOST_ADDR   (host_addr),
    .HOST_DIN    (host_din),
    .HOST_WE     (host_we),
    .HOST_DOUT   (host_dout),
    .DIRTY       (dirty)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model of one completed command; returns 1 when it commits.
  function automatic bit model_apply(input logic [1:0] opc, input logic [5:0] a,
                                     input logic [15:0] d);
    bit c;
    c = 1'b0;
    case (opc)
      2'b01: if (model_wen) begin model_mem[a] = d; c = 1'b1; end
      2'b11: if (model_wen) begin model_mem[a] = 16'hFFFF; c = 1'b1; end
      2'b00: begin
        case (a[5:4])
          2'b11: model_wen = 1'b1;
          2'b00: model_wen = 1'b0;
          2'b10: if (model_wen) begin
            for (int i = 0; i < 64; i++) model_mem[i] = 16'hFFFF;
            c = 1'b1;
          end
          default: if (model_wen) begin
            for (int i = 0; i < 64; i++) model_mem[i] = d;
            c = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
    if (c) model_dirty = 1'b1;
    return c;
  endfunction

  task automatic host_write(input logic [5:0] a, input logic [15:0] d);
    host_addr = a;
    host_din  = d;
    host_we   = 1'b1;
    @(negedge clk);
    host_we   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic host_read(input logic [5:0] a, output logic [15:0] d);
    host_addr = a;
    @(negedge clk);
    d = host_dout;
  endtask

  // One serial clock: SDO is sampled just before SCLK rises.
  task automatic sbit(input logic b, output logic so);
    sdi  = b;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    so   = sdo;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_cmd(input logic [1:0] opc, input logic [5:0] a);
    logic junk;
    int   nlead;
    scs  = 1'b0;
    sclk = 1'b0;
    sdi  = 1'b0;
    repeat (2) @(negedge clk);
    scs = 1'b1;
    repeat (2) @(negedge clk);
    nlead = $urandom_range(0, 2);
    repeat (nlead) sbit(1'b0, junk);
    sbit(1'b1, junk);
    for (int i = 1; i >= 0; i--) sbit(opc[i], junk);
    for (int i = 5; i >= 0; i--) sbit(a[i], junk);
  endtask

  task automatic send_data(input logic [15:0] d, input int nbits);
    logic junk;
    for (int i = 15; i >= 16 - nbits; i--) sbit(d[i], junk);
  endtask

  // Drop SCS, raise it again and wait (bounded) for ready on SDO.
  task automatic end_cmd();
    int cyc;
    scs = 1'b0;
    cyc = 0;
    repeat (3) begin @(negedge clk); cyc++; end
    scs = 1'b1;
    @(negedge clk); cyc++;
    first_sdo = sdo;
    while (sdo !== 1'b1 && cyc < BUSY_N + 50) begin
      @(negedge clk); cyc++;
    end
    busy_cyc = cyc;
  endtask

  task automatic run_op(input logic [1:0] opc, input logic [5:0] a,
                        input logic [15:0] d, output bit c);
    start_cmd(opc, a);
    if (opc == 2'b01 || (opc == 2'b00 && a[5:4] == 2'b01)) send_data(d, 16);
    end_cmd();
    c = model_apply(opc, a, d);
  endtask

  task automatic read_seq(input logic [5:0] a, input int nwords);
    logic        s;
    logic [15:0] w;
    start_cmd(2'b10, a);
    rd_q.delete();
    sbit(1'b0, rd_dummy);
    for (int k = 0; k < nwords; k++) begin
      for (int b = 15; b >= 0; b--) begin
        sbit(1'b0, s);
        w[b] = s;
      end
      rd_q.push_back(w);
    end
    end_cmd();
  endtask

  task automatic test_reset();
    reset = 1'b1; scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
    host_addr = 6'd0; host_din = 16'd0; host_we = 1'b0;
    model_wen = 1'b0; model_dirty = 1'b0;
    repeat (3) @(negedge clk);
    // Loader restores a blank image while reset is still held.
    for (int i = 0; i < 64; i++) host_write(6'(i), 16'hFFFF);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (sdo !== 1'b1) begin fails++; $display("FAIL reset_sdo_scs_low: got %b want 1", sdo); end
    scs = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (sdo !== 1'b1) begin fails++; $display("FAIL reset_sdo_ready: got %b want 1", sdo); end
    tests++;
    if (dirty !== 1'b0) begin fails++; $display("FAIL reset_dirty: got %b want 0", dirty); end
  endtask

  task automatic test_write_protect();
    bit c;
    run_op(2'b01, 6'd5, 16'h1234, c);
    tests++;
    if (busy_cyc !== (c ? COMMIT_CYC : IDLE_CYC)) begin
      fails++; $display("FAIL wp_busy: got %0d want %0d", busy_cyc, c ? COMMIT_CYC : IDLE_CYC);
    end
    read_seq(6'd5, 1);
    tests++;
    if (rd_dummy !== 1'b0) begin fails++; $display("FAIL wp_dummy: got %b want 0", rd_dummy); end
    tests++;
    if (rd_q[0] !== model_mem[5]) begin
      fails++; $display("FAIL wp_read: got %h want %h", rd_q[0], model_mem[5]);
    end
    tests++;
    if (dirty !== model_dirty) begin fails++; $display("FAIL wp_dirty: got %b want %b", dirty, model_dirty); end
  endtask

  task automatic test_write_read();
    bit c;
    run_op(2'b00, 6'b11_0000, 16'h0, c);
    run_op(2'b01, 6'd5, 16'hA55A, c);
    tests++;
    if (first_sdo !== 1'b0) begin fails++; $display("FAIL wr_busy_sdo: got %b want 0", first_sdo); end
    tests++;
    if (busy_cyc !== COMMIT_CYC) begin
      fails++; $display("FAIL wr_busy_len: got %0d want %0d", busy_cyc, COMMIT_CYC);
    end
    read_seq(6'd5, 1);
    tests++;
    if (rd_dummy !== 1'b0 || rd_q[0] !== 16'hA55A) begin
      fails++; $display("FAIL wr_read: got %b/%h want 0/a55a", rd_dummy, rd_q[0]);
    end
    tests++;
    if (dirty !== 1'b1) begin fails++; $display("FAIL wr_dirty: got %b want 1", dirty); end
  endtask

  task automatic test_random_ops();
    bit          c;
    logic [1:0]  opc;
    logic [5:0]  a;
    logic [15:0] d;
    int          sel, n;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 9);
      a   = 6'($urandom_range(0, 63));
      d   = 16'($urandom);
      if (sel < 5)       opc = 2'b01;
      else if (sel < 7)  opc = 2'b11;
      else if (sel < 9)  begin opc = 2'b00; a[5:4] = 2'b11; end
      else               begin opc = 2'b00; a[5:4] = 2'b00; end
      run_op(opc, a, d, c);
      tests++;
      if (busy_cyc !== (c ? COMMIT_CYC : IDLE_CYC)) begin
        fails++; $display("FAIL rand_busy[%0d] op=%b a=%0d: got %0d want %0d",
                          it, opc, a, busy_cyc, c ? COMMIT_CYC : IDLE_CYC);
      end
      if (it % 3 == 2) begin
        a = 6'($urandom_range(0, 63));
        n = $urandom_range(1, 2);
        read_seq(a, n);
        for (int k = 0; k < n; k++) begin
          tests++;
          if (rd_q[k] !== model_mem[6'(a + k)]) begin
            fails++; $display("FAIL rand_read a=%0d: got %h want %h", a + k, rd_q[k], model_mem[6'(a + k)]);
          end
        end
      end
    end
  endtask

  task automatic test_read_wrap();
    host_write(6'd63, 16'h1111);
    host_write(6'd0,  16'h2222);
    read_seq(6'd63, 2);
    tests++;
    if (rd_q[0] !== model_mem[63] || rd_q[1] !== model_mem[0]) begin
      fails++; $display("FAIL wrap_read: got %h %h want %h %h", rd_q[0], rd_q[1], model_mem[63], model_mem[0]);
    end
  endtask

  task automatic test_abort();
    bit          c;
    logic [15:0] h;
    run_op(2'b00, 6'b11_1010, 16'h0, c);
    start_cmd(2'b01, 6'd9);
    send_data(16'h5A3C, 10);
    end_cmd();
    tests++;
    if (busy_cyc !== IDLE_CYC) begin fails++; $display("FAIL abort_busy: got %0d want %0d", busy_cyc, IDLE_CYC); end
    host_read(6'd9, h);
    tests++;
    if (h !== model_mem[9]) begin fails++; $display("FAIL abort_word: got %h want %h", h, model_mem[9]); end
    run_op(2'b01, 6'd9, 16'hC3E1, c);
    read_seq(6'd9, 1);
    tests++;
    if (rd_q[0] !== model_mem[9]) begin fails++; $display("FAIL abort_next: got %h want %h", rd_q[0], model_mem[9]); end
  endtask

  task automatic test_bulk();
    bit          c;
    logic [15:0] h;
    int          bad;
    run_op(2'b00, 6'b11_0000, 16'h0, c);
    run_op(2'b00, 6'b01_0000, 16'hBEEF, c);
    tests++;
    if (busy_cyc !== COMMIT_CYC) begin fails++; $display("FAIL wral_busy: got %0d want %0d", busy_cyc, COMMIT_CYC); end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      host_read(6'(i), h);
      tests++;
      if (h !== model_mem[i]) begin fails++; $display("FAIL wral_word[%0d]: got %h want %h", i, h, model_mem[i]); end
    end
    run_op(2'b00, 6'b10_0000, 16'h0, c);
    for (int i = 0; i < 64; i++) begin
      host_read(6'(i), h);
      tests++;
      if (h !== model_mem[i]) begin fails++; $display("FAIL eral_word[%0d]: got %h want %h", i, h, model_mem[i]); end
    end
    run_op(2'b01, 6'd0, 16'h1357, c);
    run_op(2'b00, 6'b00_0000, 16'h0, c);
    run_op(2'b11, 6'd0, 16'h0, c);
    tests++;
    if (busy_cyc !== IDLE_CYC) begin fails++; $display("FAIL ewds_busy: got %0d want %0d", busy_cyc, IDLE_CYC); end
    host_read(6'd0, h);
    tests++;
    if (h !== model_mem[0]) begin fails++; $display("FAIL ewds_erase: got %h want %h", h, model_mem[0]); end
  endtask

  task automatic test_collision();
    bit          c;
    logic [15:0] h;
    run_op(2'b00, 6'b11_0000, 16'h0, c);
    start_cmd(2'b01, 6'd20);
    send_data(16'hD00D, 16);
    scs = 1'b0;
    repeat (2) @(negedge clk);
    // The commit write lands on the CLK after SCS low is detected.
    host_addr = 6'd20;
    host_din  = 16'h1111;
    host_we   = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    repeat (BUSY_N + 5) @(negedge clk);
    c = model_apply(2'b01, 6'd20, 16'hD00D);
    host_read(6'd20, h);
    tests++;
    if (h !== model_mem[20]) begin fails++; $display("FAIL collision: got %h want %h", h, model_mem[20]); end
  endtask

  task automatic test_reset_session();
    bit          c;
    logic        junk;
    logic [15:0] h;
    logic [15:0] old63;
    run_op(2'b00, 6'b11_0000, 16'h0, c);
    start_cmd(2'b10, 6'd5);
    repeat (5) sbit(1'b0, junk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (sdo !== 1'b1) begin fails++; $display("FAIL rst_sdo: got %b want 1", sdo); end
    reset = 1'b0;
    model_wen = 1'b0;
    model_dirty = 1'b0;
    tests++;
    if (dirty !== 1'b0) begin fails++; $display("FAIL rst_dirty: got %b want 0", dirty); end
    run_op(2'b01, 6'd5, 16'h7777, c);
    tests++;
    if (busy_cyc !== IDLE_CYC) begin fails++; $display("FAIL rst_wen: got %0d want %0d", busy_cyc, IDLE_CYC); end
    host_read(6'd5, h);
    tests++;
    if (h !== model_mem[5]) begin fails++; $display("FAIL rst_mem: got %h want %h", h, model_mem[5]); end
    // Reset in the middle of WRAL: early words written, late words untouched.
    old63 = model_mem[63];
    run_op(2'b00, 6'b11_0000, 16'h0, c);
    start_cmd(2'b00, 6'b01_0000);
    send_data(16'h5555, 16);
    scs = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    scs = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (sdo !== 1'b1) begin fails++; $display("FAIL rst_busy_sdo: got %b want 1", sdo); end
    host_read(6'd0, h);
    tests++;
    if (h !== 16'h5555) begin fails++; $display("FAIL rst_busy_w0: got %h want 5555", h); end
    host_read(6'd63, h);
    tests++;
    if (h !== old63) begin fails++; $display("FAIL rst_busy_w63: got %h want %h", h, old63); end
  endtask

  initial begin
    test_reset();
    test_write_protect();
    test_write_read();
    test_random_ops();
    test_read_wrap();
    test_abort();
    test_bulk();
    test_collision();
    test_reset_session();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
